// File: rtl/ccff_chain_loader.sv
// Byte-to-serial loader for the configuration flip-flop chain.
// Holds one byte ahead of an 8-bit shifter so full-rate loads shift one bit per cycle.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 11
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ccff_head,
    output logic       shift_en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] NWORDS   = CNT_W'((CHAIN_LEN + 7) / 8);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] words_in_q, words_in_d;
    logic [7:0]       buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic [7:0]       sh_reg_q, sh_reg_d;
    logic [3:0]       sh_cnt_q, sh_cnt_d;

    logic accept;
    logic load;
    logic last_bit;
    logic clr;

    assign shift_en  = (state_q == SHIFT) && (sh_cnt_q != 4'd0);
    assign in_ready  = (state_q == SHIFT) && !buf_full_q && (words_in_q < NWORDS);
    assign ccff_head = sh_reg_q[0];
    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);

    // The shifter refills on its final bit so a held-full buffer gives no bubble.
    assign accept   = in_valid && in_ready;
    assign load     = buf_full_q && ((sh_cnt_q == 4'd0) || ((sh_cnt_q == 4'd1) && shift_en));
    assign last_bit = shift_en && (bit_cnt_q == LAST_BIT);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        words_in_d = words_in_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        sh_reg_d   = sh_reg_q;
        sh_cnt_d   = sh_cnt_q;
        clr        = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    clr     = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end else begin
                    if (accept) begin
                        buf_d      = in_data;
                        words_in_d = words_in_q + CNT_W'(1);
                    end
                    if (accept) begin
                        buf_full_d = 1'b1;
                    end else if (load) begin
                        buf_full_d = 1'b0;
                    end
                    if (load) begin
                        sh_reg_d = buf_q;
                        sh_cnt_d = 4'd8;
                    end else if (shift_en) begin
                        sh_reg_d = {1'b0, sh_reg_q[7:1]};
                        sh_cnt_d = sh_cnt_q - 4'd1;
                    end
                    if (shift_en) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    // Anything left in the shifter or buffer past the chain length is dropped.
                    if (last_bit) begin
                        state_d    = DONE;
                        sh_cnt_d   = 4'd0;
                        sh_reg_d   = 8'd0;
                        buf_full_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            bit_cnt_d  = '0;
            words_in_d = '0;
            buf_d      = 8'd0;
            buf_full_d = 1'b0;
            sh_reg_d   = 8'd0;
            sh_cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            words_in_q <= '0;
            buf_q      <= 8'd0;
            buf_full_q <= 1'b0;
            sh_reg_q   <= 8'd0;
            sh_cnt_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            words_in_q <= words_in_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            sh_reg_q   <= sh_reg_d;
            sh_cnt_q   <= sh_cnt_d;
        end
    end

endmodule
